// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_RD_LAT = 1;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid = req0 | req1;
        // On a tie the requester that was not served last time wins
        if (req0 && req1) begin
            winner = ~last_served;
        end else if (req1) begin
            winner = REQ_DBG;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares a single-port synchronous-read memory between two requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    state_t            state_q, state_d;
    logic              cur_q, cur_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_q),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        // Pulse outputs are computed for the state being entered so they are registered
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cur_d      = pick_winner;
                    last_d     = pick_winner;
                    we_d       = (pick_winner == REQ_DBG) ? we1 : we0;
                    mem_addr_d = (pick_winner == REQ_DBG) ? addr1 : addr0;
                    mem_data_d = (pick_winner == REQ_DBG) ? wdata1 : wdata0;
                    mem_wren_d = we_d;
                    gnt0_d     = (pick_winner == REQ_CPU);
                    gnt1_d     = (pick_winner == REQ_DBG);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    done0_d = (cur_q == REQ_CPU);
                    done1_d = (cur_q == REQ_DBG);
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (cur_q == REQ_DBG) begin
                        rdata1_d = mem_q;
                    end else begin
                        rdata0_d = mem_q;
                    end
                    done0_d = (cur_q == REQ_CPU);
                    done1_d = (cur_q == REQ_DBG);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= REQ_CPU;
            last_q     <= REQ_DBG;
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, busy, mem_wren;
    logic [15:0] rdata0, rdata1, mem_data, mem_q;
    logic [7:0]  mem_addr;

    logic        req1_b = 0;
    logic [7:0]  addr1_b = 0;
    logic        gnt0_b, gnt1_b, done0_b, done1_b, busy_b, mem_wren_b;
    logic [15:0] rdata0_b, rdata1_b, mem_data_b, mem_q_b;
    logic [7:0]  mem_addr_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] qb1, qb2, qb3;

    int total = 0;
    int bad = 0;
    int viol = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0(1'b0), .req1(req1_b), .we0(1'b0), .we1(1'b0),
        .addr0(8'h00), .addr1(addr1_b), .wdata0(16'h0000), .wdata1(16'h0000),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b), .mem_q(mem_q_b)
    );

    always @(posedge clk) begin
        if (mem_wren) mem_a[mem_addr] <= mem_data;
        mem_q <= mem_a[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_wren_b) mem_b[mem_addr_b] <= mem_data_b;
        qb1 <= mem_b[mem_addr_b];
        qb2 <= qb1;
        qb3 <= qb2;
    end
    assign mem_q_b = qb3;

    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 && gnt1) viol++;
            if (done0 && done1) viol++;
            if ((gnt0 || gnt1) && (done0 || done1)) viol++;
            if (mem_wren && !(gnt0 || gnt1)) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int arb;
        int n;
        int done_at;
        logic got0;
        logic saw_done;
        logic [15:0] rd;

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        mem_a[1]   = 16'h0A01;
        mem_a[2]   = 16'h0B02;
        mem_b[255] = 16'h1234;

        tick();
        tick();
        chk("rst_ctl", 32'({gnt0, gnt1, done0, done1, mem_wren, busy}), 32'h0);
        chk("rst_addr", 32'({mem_addr, mem_data}), 32'h0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'h0);
        rst = 1'b0;

        // CPU write
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'hBEEF;
        tick();
        chk("wr_gnt", 32'({gnt0, gnt1, mem_wren, busy}), 32'b1011);
        chk("wr_bus", 32'({mem_addr, mem_data}), 32'h0010BEEF);
        req0 = 0;
        tick();
        chk("wr_done", 32'({gnt0, done0, done1, mem_wren, busy}), 32'b01001);
        tick();
        chk("wr_idle", 32'({done0, busy}), 32'b00);

        // CPU read back
        req0 = 1; we0 = 0;
        tick();
        chk("rd_gnt", 32'({gnt0, mem_wren}), 32'b10);
        req0 = 0;
        tick();
        chk("rd_wait", 32'({done0, busy}), 32'b01);
        tick();
        chk("rd_done", 32'(done0), 32'h1);
        chk("rd_data", 32'(rdata0), 32'hBEEF);
        chk("rd_r1", 32'(rdata1), 32'h0);
        tick();
        chk("rd_idle", 32'(busy), 32'h0);

        // Tie from reset: CPU first, then debug on the next IDLE edge
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
        tick();
        chk("tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0;
        tick(); tick();
        chk("tie_rd0", 32'({done0, rdata0}), 32'h10A01);
        tick();
        chk("tie_idle", 32'({busy, gnt1}), 32'b00);
        tick();
        chk("tie_gnt1", 32'({gnt0, gnt1}), 32'b01);
        req1 = 0;
        tick(); tick();
        chk("tie_rd1", 32'({done1, rdata1}), 32'h10B02);
        tick();
        req0 = 1; req1 = 1;
        tick();
        chk("tie2_gnt0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0; req1 = 0;
        tick(); tick(); tick();
        chk("tie2_idle", 32'(busy), 32'h0);

        // Continuous debug writes while the CPU asks once
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 16'h1111;
        tick();
        chk("stv_gnt1", 32'(gnt1), 32'h1);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        arb = 1; got0 = 0;
        for (int i = 0; i < 20 && !got0; i++) begin
            tick();
            if (gnt1) arb++;
            if (gnt0) begin
                arb++; got0 = 1; req0 = 0; req1 = 0;
            end
        end
        chk("stv_got0", 32'(got0), 32'h1);
        chk("stv_arb", 32'(arb), 32'd2);
        rd = 16'h0; saw_done = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            tick();
            if (done0) begin saw_done = 1; rd = rdata0; end
        end
        chk("stv_done", 32'({saw_done, busy}), 32'b10);
        chk("stv_rd", 32'(rd), 32'hBEEF);

        // Reset during WAIT
        req0 = 1; addr0 = 8'h01;
        tick();
        chk("rw_gnt", 32'(gnt0), 32'h1);
        req0 = 0;
        tick();
        chk("rw_wait", 32'({busy, done0}), 32'b10);
        rst = 1;
        tick();
        chk("rw_rst", 32'({busy, done0, done1}), 32'b000);
        chk("rw_clr", 32'({rdata0, mem_addr}), 32'h0);
        rst = 0;
        tick();
        chk("rw_quiet", 32'({busy, done0, gnt0}), 32'b000);

        // RD_LAT = 3 instance
        req1_b = 1; addr1_b = 8'hFF;
        tick();
        chk("l3_gnt", 32'(gnt1_b), 32'h1);
        req1_b = 0;
        n = 1; done_at = 0; rd = 16'h0;
        while (busy_b && n < 20) begin
            tick();
            n++;
            if (done1_b) begin done_at = n; rd = rdata1_b; end
        end
        chk("l3_len", 32'(n), 32'd6);
        chk("l3_done_at", 32'(done_at), 32'd5);
        chk("l3_rdata", 32'(rd), 32'h1234);

        chk("excl", 32'(viol), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
